// File: rtl/vdc_vram_host_port_if.sv
// -----------------------------------------------------------------------------
// vdc_vram_host_port_if
//
// CPU-side register access bus of the VDC VRAM host port.
// The host drives a request and the port accepts it in the cycle where
// host_valid && host_ready. host_rdata is combinational and is valid in
// that same accept cycle.
//
// Signals:
//   host_valid  host requests a register access this cycle
//   host_ready  port can accept an access (port is idle)
//   host_write  1 = register write, 0 = register read
//   host_reg    0 MAWR, 1 MARR, 2 VWR/VRR, 3 reserved
//   host_hi     0 = low byte [7:0], 1 = high byte [15:8]
//   host_wdata  write data byte
//   host_rdata  read data byte
//
// Modports:
//   master  CPU / register front end
//   slave   vdc_vram_host_port
// -----------------------------------------------------------------------------
interface vdc_vram_host_port_if;
    logic       host_valid;
    logic       host_ready;
    logic       host_write;
    logic [1:0] host_reg;
    logic       host_hi;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;

    modport master (
        output host_valid,
        output host_write,
        output host_reg,
        output host_hi,
        output host_wdata,
        input  host_ready,
        input  host_rdata
    );

    modport slave (
        input  host_valid,
        input  host_write,
        input  host_reg,
        input  host_hi,
        input  host_wdata,
        output host_ready,
        output host_rdata
    );
endinterface

// File: rtl/vdc_vram_host_port.sv
// -----------------------------------------------------------------------------
// vdc_vram_host_port
//
// Initiator side of the HuC6270 VRAM interface. CPU accesses to MAWR, MARR
// and VWR/VRR are turned into single-word VRAM read/write cycles, issued only
// in CPU slots granted by the display fetcher. Implements the HuC6270
// auto-increment (1/32/64/128) and the VRR read prefetch.
//
// Parameters:
//   ADDR_W      VRAM word-address width (MAWR, MARR, MA); at least 16
//   RD_LAT      cycles from re to valid vram_rdata
//
// Ports:
//   clock       system clock, all state updates on posedge
//   reset_N     asynchronous active-low reset
//   host        register access bus (slave modport)
//   incr_sel    address increment select: 0->1, 1->32, 2->64, 3->128
//   slot_grant  current cycle is a CPU VRAM slot
//   MA          VRAM address (0 unless a strobe is active)
//   re          VRAM read strobe, one cycle
//   we          VRAM write strobe, one cycle
//   vram_wdata  write data to VRAM (0 unless we is active)
//   vram_rdata  read data from VRAM, valid RD_LAT cycles after re
//   busy        a VRAM access is pending or in flight
//
// State table:
//   state   | meaning
//   IDLE    | no access outstanding, host accesses accepted
//   WR_WAIT | write pending, waiting for a CPU slot to pulse we
//   RD_WAIT | read pending, waiting for a CPU slot to pulse re
//   RD_DATA | read issued, waiting RD_LAT cycles for VRAM data
// -----------------------------------------------------------------------------
module vdc_vram_host_port #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset_N,
    vdc_vram_host_port_if.slave  host,
    input  logic [1:0]           incr_sel,
    input  logic                 slot_grant,
    output logic [ADDR_W-1:0]    MA,
    output logic                 re,
    output logic                 we,
    output logic [15:0]          vram_wdata,
    input  logic [15:0]          vram_rdata,
    output logic                 busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR_WAIT = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] RD_DATA = 2'd3;

    localparam int               LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    localparam logic [1:0] REG_MAWR = 2'd0;
    localparam logic [1:0] REG_MARR = 2'd1;
    localparam logic [1:0] REG_VDAT = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] mawr;
    logic [ADDR_W-1:0] marr;
    logic [7:0]        vwr_lo;
    logic [15:0]       wr_data;
    logic [15:0]       vrr;
    logic [ADDR_W-1:0] inc_amt;
    logic [LAT_W-1:0]  lat_cnt;

    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic              start_wr;
    logic              start_rd;
    logic [ADDR_W-1:0] inc_decoded;

    // ------------------------------------------------------------------
    // Host side decode
    // ------------------------------------------------------------------
    assign host.host_ready = (state == IDLE);
    assign busy            = (state != IDLE);

    assign accept = host.host_valid && host.host_ready;
    assign wr_acc = accept &&  host.host_write;
    assign rd_acc = accept && !host.host_write;

    // A high-byte write to VWR commits the word; a high-byte write to MARR
    // or a high-byte read of VRR launches a (pre)fetch.
    assign start_wr = wr_acc && (host.host_reg == REG_VDAT) && host.host_hi;
    assign start_rd = (wr_acc && (host.host_reg == REG_MARR) && host.host_hi) ||
                      (rd_acc && (host.host_reg == REG_VDAT) && host.host_hi);

    always_comb begin
        host.host_rdata = 8'h00;
        if (!host.host_write && (host.host_reg == REG_VDAT)) begin
            host.host_rdata = host.host_hi ? vrr[15:8] : vrr[7:0];
        end
    end

    always_comb begin
        inc_decoded = ADDR_W'(1);
        case (incr_sel)
            2'd0:    inc_decoded = ADDR_W'(1);
            2'd1:    inc_decoded = ADDR_W'(32);
            2'd2:    inc_decoded = ADDR_W'(64);
            default: inc_decoded = ADDR_W'(128);
        endcase
    end

    // ------------------------------------------------------------------
    // VRAM side: strobes come straight from state and slot_grant so that
    // an asynchronous reset clears them in the same instant, and so that
    // nothing toggles on the bus while a slot is withheld.
    // ------------------------------------------------------------------
    assign we = (state == WR_WAIT) && slot_grant;
    assign re = (state == RD_WAIT) && slot_grant;

    always_comb begin
        MA         = '0;
        vram_wdata = 16'h0000;
        if (we) begin
            MA         = mawr;
            vram_wdata = wr_data;
        end else if (re) begin
            MA = marr;
        end
    end

    // ------------------------------------------------------------------
    // Registers and FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state   <= IDLE;
            mawr    <= '0;
            marr    <= '0;
            vwr_lo  <= 8'h00;
            wr_data <= 16'h0000;
            vrr     <= 16'h0000;
            inc_amt <= '0;
            lat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_acc) begin
                        case (host.host_reg)
                            REG_MAWR: begin
                                if (host.host_hi) mawr[15:8] <= host.host_wdata;
                                else              mawr[7:0]  <= host.host_wdata;
                            end
                            REG_MARR: begin
                                if (host.host_hi) marr[15:8] <= host.host_wdata;
                                else              marr[7:0]  <= host.host_wdata;
                            end
                            REG_VDAT: begin
                                if (host.host_hi) wr_data <= {host.host_wdata, vwr_lo};
                                else              vwr_lo  <= host.host_wdata;
                            end
                            default: ;
                        endcase
                    end

                    // The increment is frozen here so a CR change while the
                    // access waits for a slot does not affect it.
                    if (start_wr) begin
                        inc_amt <= inc_decoded;
                        state   <= WR_WAIT;
                    end else if (start_rd) begin
                        inc_amt <= inc_decoded;
                        state   <= RD_WAIT;
                    end
                end

                WR_WAIT: begin
                    if (slot_grant) begin
                        mawr  <= mawr + inc_amt;
                        state <= IDLE;
                    end
                end

                RD_WAIT: begin
                    if (slot_grant) begin
                        lat_cnt <= LAT_LOAD;
                        state   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (lat_cnt == '0) begin
                        vrr   <= vram_rdata;
                        marr  <= marr + inc_amt;
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
